// File: rtl/regfile_sb_if.sv
// regfile_sb_if: operand-read, allocate and writeback bundle for regfile_sb.
// master drives the requests; slave is the register file.
interface regfile_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NRD    = 2,
    parameter int TAG_W  = 3
);
    logic                    flush;
    logic                    alloc_en;
    logic [ADDR_W-1:0]       alloc_addr;
    logic [TAG_W-1:0]        alloc_tag;
    logic                    wb_en;
    logic [ADDR_W-1:0]       wb_addr;
    logic [TAG_W-1:0]        wb_tag;
    logic [DATA_W-1:0]       wb_data;
    logic [NRD-1:0]          re;
    logic [NRD*ADDR_W-1:0]   raddr;
    logic [NRD*DATA_W-1:0]   rdata;
    logic [NRD-1:0]          rbusy;
    logic [NRD*TAG_W-1:0]    rtag;
    logic [ADDR_W:0]         busy_cnt;

    modport master (
        output flush, alloc_en, alloc_addr, alloc_tag,
        output wb_en, wb_addr, wb_tag, wb_data,
        output re, raddr,
        input  rdata, rbusy, rtag, busy_cnt
    );

    modport slave (
        input  flush, alloc_en, alloc_addr, alloc_tag,
        input  wb_en, wb_addr, wb_tag, wb_data,
        input  re, raddr,
        output rdata, rbusy, rtag, busy_cnt
    );
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb: integer register file with per-register busy/tag scoreboard,
// combinational reads with writeback bypass; x0 hardwired to zero.
module regfile_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NRD    = 2,
    parameter int TAG_W  = 3
) (
    input logic         clk,
    input logic         rst,
    regfile_sb_if.slave rf
);
    localparam int NREG = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [DATA_W-1:0] data [NREG];
    logic [TAG_W-1:0]  tag  [NREG];
    logic [NREG-1:0]   busy;
    logic [ADDR_W:0]   cnt;

    logic alloc_v;
    logic wb_v;
    logic wb_clr;
    logic same;
    logic inc;
    logic dec;

    always_comb begin
        alloc_v = rf.alloc_en && (rf.alloc_addr != '0) && !rf.flush;
        wb_v    = rf.wb_en && (rf.wb_addr != '0);
        wb_clr  = wb_v && busy[rf.wb_addr]
                  && (tag[rf.wb_addr] == rf.wb_tag);
        same    = alloc_v && (rf.alloc_addr == rf.wb_addr);
        inc     = alloc_v && !busy[rf.alloc_addr];
        // a clear overridden by a same-address alloc leaves busy set
        dec     = wb_clr && !same;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NREG; k++) begin
                data[k] <= '0;
                tag[k]  <= '0;
            end
            busy <= '0;
            cnt  <= '0;
        end else begin
            if (wb_v)
                data[rf.wb_addr] <= rf.wb_data;
            if (rf.flush) begin
                busy <= '0;
                cnt  <= '0;
            end else begin
                if (wb_clr)
                    busy[rf.wb_addr] <= 1'b0;
                if (alloc_v) begin
                    busy[rf.alloc_addr] <= 1'b1;
                    tag[rf.alloc_addr]  <= rf.alloc_tag;
                end
                if (inc && !dec)
                    cnt <= cnt + ONE;
                else if (dec && !inc)
                    cnt <= cnt - ONE;
            end
        end
    end

    assign rf.busy_cnt = cnt;

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] d;
        logic [TAG_W-1:0]  t;
        logic              b;

        assign ra = rf.raddr[i*ADDR_W +: ADDR_W];

        always_comb begin
            d = '0;
            b = 1'b0;
            t = '0;
            if (!rst && rf.re[i] && (ra != '0)) begin
                if (wb_v && (rf.wb_addr == ra)) begin
                    d = rf.wb_data;
                    b = busy[ra] && (tag[ra] != rf.wb_tag);
                end else begin
                    d = data[ra];
                    b = busy[ra];
                end
                t = b ? tag[ra] : '0;
            end
        end

        assign rf.rdata[i*DATA_W +: DATA_W] = d;
        assign rf.rbusy[i]                  = b;
        assign rf.rtag[i*TAG_W +: TAG_W]    = t;
    end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed vectors for regfile_sb with hand-computed
// expectations for bypass, scoreboard, collisions, flush and reset.
module tb_regfile_sb;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_pass = 0;

    regfile_sb_if #(.DATA_W(32), .ADDR_W(5), .NRD(2), .TAG_W(3)) rf_if ();

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .NRD(2), .TAG_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .rf  (rf_if)
    );

    always #5 clk = ~clk;

    wire [31:0] rd0 = rf_if.rdata[31:0];
    wire [31:0] rd1 = rf_if.rdata[63:32];
    wire        rb0 = rf_if.rbusy[0];
    wire        rb1 = rf_if.rbusy[1];
    wire [2:0]  rt0 = rf_if.rtag[2:0];
    wire [5:0]  cnt = rf_if.busy_cnt;

    task automatic chk(input string t, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", t, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rf_if.flush    = 1'b0;
        rf_if.alloc_en = 1'b0;
        rf_if.wb_en    = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
        rf_if.re    = 2'b11;
        rf_if.raddr = {a1, a0};
    endtask

    task automatic alloc(input logic [4:0] a, input logic [2:0] t);
        rf_if.alloc_en   = 1'b1;
        rf_if.alloc_addr = a;
        rf_if.alloc_tag  = t;
    endtask

    task automatic wb(input logic [4:0] a, input logic [2:0] t,
                      input logic [31:0] d);
        rf_if.wb_en   = 1'b1;
        rf_if.wb_addr = a;
        rf_if.wb_tag  = t;
        rf_if.wb_data = d;
    endtask

    initial begin
        idle();
        rf_if.alloc_addr = '0;
        rf_if.alloc_tag  = '0;
        rf_if.wb_addr    = '0;
        rf_if.wb_tag     = '0;
        rf_if.wb_data    = '0;
        rd(5'd5, 5'd31);
        #3;
        chk("rst_rdata0", rd0, 32'h0);
        chk("rst_cnt", {26'd0, cnt}, 32'd0);
        tick();
        #2 rst = 1'b0;
        #1;
        chk("x5_rdata", rd0, 32'h0);
        chk("x31_rdata", rd1, 32'h0);
        chk("x5_x31_busy", {30'd0, rb1, rb0}, 32'd0);
        chk("init_cnt", {26'd0, cnt}, 32'd0);

        tick();
        wb(5'd3, 3'd0, 32'hDEADBEEF);
        rd(5'd3, 5'd0);
        #1;
        chk("byp_x3", rd0, 32'hDEADBEEF);
        chk("x0_port1", rd1, 32'h0);
        tick();
        idle();
        #1;
        chk("x3_held", rd0, 32'hDEADBEEF);

        alloc(5'd7, 3'd2);
        rd(5'd7, 5'd7);
        #1;
        chk("alloc_not_byp", {31'd0, rb0}, 32'd0);
        tick();
        idle();
        #1;
        chk("x7_busy", {31'd0, rb0}, 32'd1);
        chk("x7_tag", {29'd0, rt0}, 32'd2);
        chk("cnt_1", {26'd0, cnt}, 32'd1);

        wb(5'd7, 3'd1, 32'h11);
        #1;
        chk("stale_byp_data", rd0, 32'h11);
        chk("stale_byp_busy", {31'd0, rb0}, 32'd1);
        tick();
        idle();
        #1;
        chk("stale_data", rd0, 32'h11);
        chk("stale_busy", {31'd0, rb0}, 32'd1);
        chk("stale_cnt", {26'd0, cnt}, 32'd1);

        wb(5'd7, 3'd2, 32'h22);
        #1;
        chk("match_byp_busy", {31'd0, rb0}, 32'd0);
        chk("match_byp_tag", {29'd0, rt0}, 32'd0);
        tick();
        idle();
        #1;
        chk("x7_clear", {31'd0, rb0}, 32'd0);
        chk("x7_data", rd0, 32'h22);
        chk("cnt_0", {26'd0, cnt}, 32'd0);

        alloc(5'd4, 3'd5);
        tick();
        alloc(5'd4, 3'd5);
        wb(5'd4, 3'd5, 32'h44);
        rd(5'd4, 5'd4);
        tick();
        idle();
        #1;
        chk("coll_busy", {31'd0, rb0}, 32'd1);
        chk("coll_tag", {29'd0, rt0}, 32'd5);
        chk("coll_data", rd0, 32'h44);
        chk("coll_cnt", {26'd0, cnt}, 32'd1);

        alloc(5'd8, 3'd3);
        wb(5'd8, 3'd3, 32'h88);
        tick();
        idle();
        rd(5'd8, 5'd4);
        #1;
        chk("coll_new_busy", {31'd0, rb0}, 32'd1);
        chk("coll_new_cnt", {26'd0, cnt}, 32'd2);

        alloc(5'd9, 3'd1);
        wb(5'd4, 3'd5, 32'h45);
        tick();
        idle();
        rd(5'd9, 5'd4);
        #1;
        chk("net0_x9", {31'd0, rb0}, 32'd1);
        chk("net0_x4", {31'd0, rb1}, 32'd0);
        chk("net0_cnt", {26'd0, cnt}, 32'd2);

        alloc(5'd0, 3'd6);
        wb(5'd0, 3'd6, 32'hFF);
        rd(5'd0, 5'd0);
        #1;
        chk("x0_byp", rd0, 32'h0);
        tick();
        idle();
        #1;
        chk("x0_data", rd0, 32'h0);
        chk("x0_busy", {31'd0, rb0}, 32'd0);
        chk("x0_cnt", {26'd0, cnt}, 32'd2);

        alloc(5'd1, 3'd1);
        tick();
        alloc(5'd2, 3'd2);
        tick();
        alloc(5'd9, 3'd4);
        tick();
        idle();
        rd(5'd9, 5'd1);
        #1;
        chk("realloc_tag", {29'd0, rt0}, 32'd4);
        chk("pre_flush_cnt", {26'd0, cnt}, 32'd4);
        rf_if.flush = 1'b1;
        alloc(5'd10, 3'd7);
        wb(5'd1, 3'd0, 32'h55);
        tick();
        idle();
        rd(5'd1, 5'd10);
        #1;
        chk("fl_x1_data", rd0, 32'h55);
        chk("fl_busy", {30'd0, rb1, rb0}, 32'd0);
        chk("fl_cnt", {26'd0, cnt}, 32'd0);
        rd(5'd2, 5'd9);
        #1;
        chk("fl_x2_x9", {30'd0, rb1, rb0}, 32'd0);

        alloc(5'd6, 3'd3);
        wb(5'd6, 3'd0, 32'h66);
        tick();
        idle();
        rd(5'd6, 5'd6);
        #1;
        chk("x6_data", rd0, 32'h66);
        chk("x6_busy", {31'd0, rb0}, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("arst_data", rd0, 32'h0);
        chk("arst_busy", {31'd0, rb0}, 32'd0);
        chk("arst_cnt", {26'd0, cnt}, 32'd0);
        #1 rst = 1'b0;
        #1;
        chk("post_data", rd0, 32'h0);
        chk("post_busy", {31'd0, rb0}, 32'd0);
        tick();
        chk("post_edge_cnt", {26'd0, cnt}, 32'd0);
        chk("post_edge_data", rd1, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
